// File: rtl/hdecoder_pkg.sv
// Shared types and constants for the Huffman decoder output path.
package hdecoder_pkg;

    localparam int unsigned SYM_W        = 4;
    localparam int unsigned MAX_CODE_LEN = 10;
    localparam int unsigned WORD_W       = 32;

    typedef logic [SYM_W-1:0]  sym_t;
    typedef logic [3:0]        len_t;
    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic {
        ACCUM = 1'b0,
        FLUSH = 1'b1
    } state_t;

endpackage

// File: rtl/hdecoder_word_fifo.sv
// Synchronous FIFO with a registered head: head_data/head_valid are flops
// that always show the oldest stored entry.
module hdecoder_word_fifo #(
    parameter int unsigned WIDTH = 36,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             head_valid_q, head_valid_d;
    logic             push_en, pop_en;

    assign full       = (count_q == (PTR_W+1)'(DEPTH));
    assign empty      = (count_q == '0);
    assign head_valid = head_valid_q;
    assign head_data  = head_q;

    always_comb begin
        pop_en   = pop && !empty;
        push_en  = push && (!full || pop_en);
        wr_ptr_d = wr_ptr_q + PTR_W'(push_en);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_en);
        count_d  = count_q;
        if (push_en && !pop_en) begin
            count_d = count_q + 1'b1;
        end else if (pop_en && !push_en) begin
            count_d = count_q - 1'b1;
        end
        // Next head may be the word being written this very edge (empty, or one
        // entry left and being popped), so bypass the array in that case.
        head_valid_d = (count_d != '0);
        head_d       = '0;
        if (count_d != '0) begin
            if (push_en && (wr_ptr_q == rd_ptr_d)) begin
                head_d = push_data;
            end else begin
                head_d = mem_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            head_q       <= '0;
            head_valid_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            head_q       <= head_d;
            head_valid_q <= head_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/hdecoder_symbol_packer.sv
// Packs decoded symbols LSB-first into words, queues them for writeback and
// keeps running symbol/bit totals for stream accounting.
module hdecoder_symbol_packer #(
    parameter int unsigned SYM_W         = 4,
    parameter int unsigned SYMS_PER_WORD = 8,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           sym_valid,
    input  logic [SYM_W-1:0]               sym_data,
    input  logic [3:0]                     sym_len,
    input  logic                           flush,
    output logic                           sym_ready,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [SYM_W*SYMS_PER_WORD-1:0] out_data,
    output logic [3:0]                     out_count,
    output logic                           overflow,
    output logic [15:0]                    sym_total,
    output logic [23:0]                    bit_total
);

    import hdecoder_pkg::*;

    localparam int unsigned WORD_BITS = SYM_W * SYMS_PER_WORD;
    localparam int unsigned CNT_W     = 4;
    localparam int unsigned ENTRY_W   = WORD_BITS + CNT_W;

    state_t               state_q, state_d;
    logic [WORD_BITS-1:0] acc_q, acc_d, acc_after;
    logic [CNT_W-1:0]     acc_cnt_q, acc_cnt_d, cnt_after;
    logic                 overflow_q, overflow_d;
    logic [15:0]          sym_total_q, sym_total_d;
    logic [23:0]          bit_total_q, bit_total_d;

    logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [ENTRY_W-1:0]   fifo_push_data, fifo_head;
    logic                 accept;

    hdecoder_word_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (fifo_push),
        .push_data  (fifo_push_data),
        .pop        (fifo_pop),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .head_valid (out_valid),
        .head_data  (fifo_head)
    );

    assign out_data  = fifo_head[WORD_BITS-1:0];
    assign out_count = fifo_head[ENTRY_W-1:WORD_BITS];
    assign overflow  = overflow_q;
    assign sym_total = sym_total_q;
    assign bit_total = bit_total_q;
    assign fifo_pop  = out_valid && out_ready;

    // Hold off a symbol that would complete a word with no FIFO slot to take it.
    assign sym_ready = (state_q == ACCUM) &&
                       !(fifo_full && (acc_cnt_q == CNT_W'(SYMS_PER_WORD - 1)));
    assign accept    = sym_valid && sym_ready;

    always_comb begin
        acc_after = acc_q;
        if (accept) begin
            acc_after[acc_cnt_q*SYM_W +: SYM_W] = sym_data;
        end
        cnt_after = acc_cnt_q + CNT_W'(accept);

        state_d        = state_q;
        acc_d          = acc_after;
        acc_cnt_d      = cnt_after;
        fifo_push      = 1'b0;
        fifo_push_data = {cnt_after, acc_after};
        overflow_d     = overflow_q || (sym_valid && !sym_ready);
        sym_total_d    = sym_total_q;
        bit_total_d    = bit_total_q;

        if (accept) begin
            sym_total_d = sym_total_q + 16'd1;
            bit_total_d = bit_total_q + 24'(sym_len);
        end

        unique case (state_q)
            ACCUM: begin
                if (cnt_after == CNT_W'(SYMS_PER_WORD)) begin
                    fifo_push = 1'b1;
                    acc_d     = '0;
                    acc_cnt_d = '0;
                end else if (flush && (cnt_after != '0)) begin
                    if (!fifo_full || fifo_pop) begin
                        fifo_push = 1'b1;
                        acc_d     = '0;
                        acc_cnt_d = '0;
                    end else begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (!fifo_full) begin
                    fifo_push = 1'b1;
                    acc_d     = '0;
                    acc_cnt_d = '0;
                    state_d   = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            acc_cnt_q   <= '0;
            overflow_q  <= 1'b0;
            sym_total_q <= '0;
            bit_total_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            acc_cnt_q   <= acc_cnt_d;
            overflow_q  <= overflow_d;
            sym_total_q <= sym_total_d;
            bit_total_q <= bit_total_d;
        end
    end

endmodule

// File: tb/tb_hdecoder_symbol_packer.sv
// Scenario bench for hdecoder_symbol_packer: expected words are queued as
// stimulus is driven and compared whenever the packer hands a word over.
module tb_hdecoder_symbol_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        sym_valid;
    logic [3:0]  sym_data;
    logic [3:0]  sym_len;
    logic        flush;
    logic        sym_ready;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_count;
    logic        overflow;
    logic [15:0] sym_total;
    logic [23:0] bit_total;

    int          checks = 0;
    int          errors = 0;
    logic [35:0] sb [$];
    logic [35:0] mon_exp;

    hdecoder_symbol_packer #(
        .SYM_W         (4),
        .SYMS_PER_WORD (8),
        .FIFO_DEPTH    (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sym_valid (sym_valid),
        .sym_data  (sym_data),
        .sym_len   (sym_len),
        .flush     (flush),
        .sym_ready (sym_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .overflow  (overflow),
        .sym_total (sym_total),
        .bit_total (bit_total)
    );

    always #5 clk = ~clk;

    // Every handed-over word must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL word_unexpected got count=%0d data=%h required no word", out_count, out_data);
            end else begin
                mon_exp = sb.pop_front();
                if ({out_count, out_data} !== mon_exp) begin
                    errors++;
                    $display("FAIL word_order got count=%0d data=%h required count=%0d data=%h",
                             out_count, out_data, mon_exp[35:32], mon_exp[31:0]);
                end
            end
        end
    end

    task automatic cyc(input logic v, input logic [3:0] d, input logic [3:0] l, input logic f);
        sym_valid = v;
        sym_data  = d;
        sym_len   = l;
        flush     = f;
        @(posedge clk);
        #1;
        sym_valid = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        sym_valid = 1'b0;
        sym_data  = '0;
        sym_len   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic drain(input string name);
        out_ready = 1'b1;
        for (int n = 0; n < 20 && sb.size() != 0; n++) cyc(1'b0, 4'd0, 4'd0, 1'b0);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain_timeout got %0d words left required 0", name, sb.size());
        end
    endtask

    task automatic test_reset();
        do_reset();
        cyc(1'b1, 4'h5, 4'd3, 1'b0);
        do_reset();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_count !== 4'd0) begin
            errors++;
            $display("FAIL reset_outputs got valid=%b data=%h count=%0d required 0/0/0", out_valid, out_data, out_count);
        end
        checks++;
        if (overflow !== 1'b0 || sym_total !== 16'd0 || bit_total !== 24'd0) begin
            errors++;
            $display("FAIL reset_counters got ovf=%b sym=%0d bit=%0d required 0/0/0", overflow, sym_total, bit_total);
        end
        checks++;
        if (sym_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b required 1", sym_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_full_word();
        do_reset();
        out_ready = 1'b1;
        sb.push_back({4'd8, 32'h87654321});
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b1, 4'(i), 4'd4, 1'b0);
            if (i == 7) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL full_word_early got valid=%b required 0", out_valid);
                end
            end
        end
        checks++;
        if (out_valid !== 1'b1 || out_count !== 4'd8) begin
            errors++;
            $display("FAIL full_word_latency got valid=%b count=%0d required 1/8", out_valid, out_count);
        end
        checks++;
        if (sym_total !== 16'd8 || bit_total !== 24'd32) begin
            errors++;
            $display("FAIL full_word_totals got sym=%0d bit=%0d required 8/32", sym_total, bit_total);
        end
        cyc(1'b0, 4'd0, 4'd0, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL full_word_popped got valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_partial_flush();
        do_reset();
        out_ready = 1'b1;
        sb.push_back({4'd3, 32'h00000CBA});
        cyc(1'b1, 4'hA, 4'd5, 1'b0);
        cyc(1'b1, 4'hB, 4'd6, 1'b0);
        cyc(1'b1, 4'hC, 4'd7, 1'b0);
        cyc(1'b0, 4'd0, 4'd0, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_count !== 4'd3) begin
            errors++;
            $display("FAIL partial_word got valid=%b count=%0d required 1/3", out_valid, out_count);
        end
        cyc(1'b0, 4'd0, 4'd0, 1'b0);
        cyc(1'b0, 4'd0, 4'd0, 1'b1);
        for (int n = 0; n < 3; n++) begin
            cyc(1'b0, 4'd0, 4'd0, 1'b0);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL empty_flush_word got valid=%b required 0", out_valid);
            end
        end
        checks++;
        if (sym_total !== 16'd3 || bit_total !== 24'd18) begin
            errors++;
            $display("FAIL partial_totals got sym=%0d bit=%0d required 3/18", sym_total, bit_total);
        end
    endtask

    task automatic test_fill_overflow();
        logic [31:0] w;
        logic [23:0] eb;
        do_reset();
        w  = '0;
        eb = '0;
        for (int i = 0; i < 40; i++) begin
            if (i < 32) begin
                w[(i % 8) * 4 +: 4] = 4'(i);
                if (i % 8 == 7) sb.push_back({4'd8, w});
            end
            if (i < 39) eb = eb + 24'((i % 10) + 1);
            cyc(1'b1, 4'(i), 4'((i % 10) + 1), 1'b0);
            if (i == 30 || i == 38) begin
                checks++;
                if (sym_ready !== (i == 30)) begin
                    errors++;
                    $display("FAIL fill_ready_%0d got %b required %b", i, sym_ready, (i == 30));
                end
            end
        end
        checks++;
        if (overflow !== 1'b1 || sym_total !== 16'd39 || bit_total !== eb) begin
            errors++;
            $display("FAIL fill_overflow got ovf=%b sym=%0d bit=%0d required 1/39/%0d", overflow, sym_total, bit_total, eb);
        end
        cyc(1'b0, 4'd0, 4'd0, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_count !== 4'd8 || out_data !== 32'h76543210) begin
            errors++;
            $display("FAIL fill_head_hold got valid=%b count=%0d data=%h required 1/8/76543210", out_valid, out_count, out_data);
        end
        drain("fill");
        checks++;
        if (sym_ready !== 1'b1 || overflow !== 1'b1 || sym_total !== 16'd39) begin
            errors++;
            $display("FAIL fill_after_drain got rdy=%b ovf=%b sym=%0d required 1/1/39", sym_ready, overflow, sym_total);
        end
    endtask

    task automatic test_flush_blocked();
        logic [31:0] w;
        do_reset();
        w = '0;
        for (int i = 0; i < 37; i++) begin
            w[(i % 8) * 4 +: 4] = 4'(i * 3);
            if (i % 8 == 7) begin
                sb.push_back({4'd8, w});
                w = '0;
            end
            cyc(1'b1, 4'(i * 3), 4'd2, 1'b0);
        end
        sb.push_back({4'd5, w});
        cyc(1'b0, 4'd0, 4'd0, 1'b1);
        checks++;
        if (sym_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL flush_blocked_state got rdy=%b valid=%b required 0/1", sym_ready, out_valid);
        end
        out_ready = 1'b1;
        cyc(1'b0, 4'd0, 4'd0, 1'b1);
        out_ready = 1'b0;
        checks++;
        if (sym_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_pending got rdy=%b required 0", sym_ready);
        end
        cyc(1'b0, 4'd0, 4'd0, 1'b0);
        checks++;
        if (sym_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_back_accum got rdy=%b required 1", sym_ready);
        end
        checks++;
        if (sym_total !== 16'd37 || bit_total !== 24'd74) begin
            errors++;
            $display("FAIL flush_totals got sym=%0d bit=%0d required 37/74", sym_total, bit_total);
        end
        drain("flush_blocked");
    endtask

    task automatic test_cnt7_flush();
        logic [31:0] w;
        do_reset();
        out_ready = 1'b1;
        w = '0;
        for (int i = 0; i < 8; i++) w[i * 4 +: 4] = 4'(15 - i);
        sb.push_back({4'd8, w});
        for (int i = 0; i < 8; i++) cyc(1'b1, 4'(15 - i), 4'd1, 1'(i == 7));
        checks++;
        if (out_valid !== 1'b1 || out_count !== 4'd8) begin
            errors++;
            $display("FAIL cnt7_flush_word got valid=%b count=%0d required 1/8", out_valid, out_count);
        end
        for (int n = 0; n < 3; n++) cyc(1'b0, 4'd0, 4'd0, 1'b0);
        checks++;
        if (out_valid !== 1'b0 || sym_total !== 16'd8 || bit_total !== 24'd8) begin
            errors++;
            $display("FAIL cnt7_flush_after got valid=%b sym=%0d bit=%0d required 0/8/8", out_valid, sym_total, bit_total);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] w;
        do_reset();
        for (int i = 0; i < 20; i++) cyc(1'b1, 4'(i + 1), 4'd9, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || sym_total !== 16'd20) begin
            errors++;
            $display("FAIL mid_setup got valid=%b sym=%0d required 1/20", out_valid, sym_total);
        end
        rst = 1'b1;
        cyc(1'b0, 4'd0, 4'd0, 1'b0);
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || sym_total !== 16'd0 || bit_total !== 24'd0 ||
            overflow !== 1'b0 || sym_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset got valid=%b sym=%0d bit=%0d ovf=%b rdy=%b required 0/0/0/0/1",
                     out_valid, sym_total, bit_total, overflow, sym_ready);
        end
        out_ready = 1'b1;
        w = '0;
        for (int i = 0; i < 8; i++) w[i * 4 +: 4] = 4'(i + 5);
        sb.push_back({4'd8, w});
        for (int i = 0; i < 8; i++) cyc(1'b1, 4'(i + 5), 4'd10, 1'b0);
        drain("mid_reset");
        checks++;
        if (sym_total !== 16'd8 || bit_total !== 24'd80) begin
            errors++;
            $display("FAIL mid_after_totals got sym=%0d bit=%0d required 8/80", sym_total, bit_total);
        end
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_partial_flush();
        test_fill_overflow();
        test_flush_blocked();
        test_cnt7_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hdecoder_symbol_packer.md
Name: hdecoder_symbol_packer

Overview:
- Downstream stage of the Huffman decoder.
- Accepts one 4-bit decoded symbol per ready-strobe, plus its code length.
- Packs symbols LSB-first into 32-bit words and buffers them in a small FIFO.
- Emits words over a valid/ready stream toward the output DMA/writeback, and tracks compressed-bit and symbol totals for stream accounting.

Parameters:
- SYM_W, 4, width of one decoded symbol.
- SYMS_PER_WORD, 8, symbols per output word (word width = SYM_W*SYMS_PER_WORD = 32).
- FIFO_DEPTH, 4, output word FIFO entries (power of two, >=2).

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- sym_valid  in  1  decoder strobe: symbol present this cycle.
- sym_data  in  4  decoded symbol.
- sym_len  in  4  code length of this symbol, in bits (1..10).
- flush  in  1  end of stream: emit any partial word.
- sym_ready  out  1  packer can accept a symbol this cycle.
- out_valid  out  1  FIFO head word valid.
- out_ready  in  1  consumer accepts the head word.
- out_data  out  32  packed word; symbol k occupies bits [4k+3:4k].
- out_count  out  4  number of valid symbols in out_data (1..8).
- overflow  out  1  sticky: a symbol arrived while sym_ready=0.
- sym_total  out  16  symbols accepted since reset; wraps.
- bit_total  out  24  sum of sym_len of accepted symbols; wraps.

Behaviour:
- Reset (clk edge with rst=1), regardless of state:
  - Clears the accumulator, acc_cnt, the FIFO pointers and the state.
  - All outputs take their reset values: out_valid=0, out_data=0, out_count=0, overflow=0, sym_total=0, bit_total=0, sym_ready=1.
  - Words held in the FIFO are discarded.
- Accept: a symbol is accepted when sym_valid && sym_ready.
  - sym_data is written into accumulator slot acc_cnt; acc_cnt increments.
  - sym_total increments by 1; bit_total increments by zero-extended sym_len.
- Word complete: when the accepted symbol is slot 7, the full word is pushed to the FIFO on the same edge with count 8.
  - acc_cnt returns to 0 and the accumulator clears.
  - out_valid is high in the following cycle if the FIFO was previously empty, so latency is 1 cycle.
- sym_ready = 0 when:
  - state is FLUSH, or
  - the FIFO is full and acc_cnt==7 (a completed word would have nowhere to go).
  - Otherwise sym_ready = 1.
- Overflow: sym_valid while sym_ready=0 drops the symbol.
  - overflow is set and stays set until reset.
  - The counters are not updated.
- FIFO behaviour:
  - A pop occurs when out_valid && out_ready.
  - Push and pop on the same edge are legal when full or empty; occupancy is unchanged.
  - out_data and out_count reflect the FIFO head, are registered, and hold stable while out_valid && !out_ready.
- State machine: ACCUM, FLUSH.
  - ACCUM: flush=1 with acc_cnt>0 (after counting any symbol accepted that same cycle):
    - If the FIFO has space, or is popping that cycle, push a partial word: upper nibbles zero, out_count=acc_cnt. acc_cnt returns to 0 and the state stays ACCUM.
    - Otherwise go to FLUSH.
  - ACCUM: flush=1 with acc_cnt==0 (including when the same-cycle symbol completed a word) is a no-op.
  - FLUSH: push the partial word on the first cycle the FIFO is not full, then return to ACCUM. The flush input is ignored while in FLUSH.
- Simultaneous sym_valid and flush: the symbol is accepted first and included in the flushed word.
- Counters wrap modulo 2^16 and 2^24 with no saturation or flag.

Decomposition:
- Shared package hdecoder_pkg holds:
  - SYM_W, MAX_CODE_LEN=10, WORD_W=32.
  - Typedefs sym_t [3:0], len_t [3:0], word_t [31:0].
  - State enum {ACCUM, FLUSH}.
- One sub-module: hdecoder_word_fifo, a synchronous FIFO.
  - Parameters: width 36 (data plus count) and depth FIFO_DEPTH.
  - Ports: push, pop, full, empty.
  - Registered head output.
- Packing logic, counters and the FSM stay in the top module.

Test Plan:
- 8 symbols 1..8 on consecutive cycles, sym_len=4 each, out_ready=1 -> one word 0x87654321, out_count=8, out_valid high the cycle after the 8th symbol; sym_total=8, bit_total=32.
- 3 symbols A,B,C then flush -> word 0x00000CBA, out_count=3; a second flush with acc_cnt=0 produces no word.
- out_ready=0, stream 40 symbols -> FIFO fills with 4 words, sym_ready drops when acc_cnt=7; the 40th symbol sets overflow=1 and sym_total=39. Raise out_ready -> 4 words drain in order, sym_ready returns to 1.
- FIFO full, acc_cnt=5, flush -> state FLUSH and sym_ready=0; one pop leads to the partial word being pushed next edge (out_count=5), then back to ACCUM.
- acc_cnt=7 with sym_valid and flush together -> full word with out_count=8, no extra partial word.
- Assert rst mid-stream (acc_cnt=4, FIFO holding 2 words) -> next cycle out_valid=0, counters 0, overflow 0, sym_ready=1; old data never appears.
